mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline memory stage with a multi-cycle data-memory access.
//
// A request is accepted only while idle. Its command, address and store data
// are latched, WAIT_CYCLES wait states elapse, and the access then commits on
// a single clock edge. A one-cycle o_mem_ready pulse follows, with o_mem_err
// qualifying it. Addresses are byte addresses and byte lanes are
// little-endian.
//
// Configuration macro:
//   MEM_BYTE_ACCESS_EN  defined   : i_byte_op selects byte (sb/lb) accesses.
//                       undefined : i_byte_op is ignored and every access is
//                                   a word access.
//
// Parameters:
//   MEM_WORDS    data memory depth in 32-bit words (power of two)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   i_clk           sole clock; all state updates on the rising edge
//   i_rst_n         synchronous active-low reset
//   i_mem_start     access request, sampled only while idle
//   i_mem_wr_en     1 = store, 0 = load
//   i_byte_op       1 = byte access, 0 = word access
//   i_alu_mem_addr  byte address from the ALU stage
//   i_mem_data_in   store data (byte stores use bits 7:0)
//   o_mem_data_out  registered load result; holds until the next good load
//   o_mem_ready     one-cycle completion pulse
//   o_mem_busy      high while an access is in flight
//   o_mem_err       valid with o_mem_ready; 1 = access rejected
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_start,
  input  logic        i_mem_wr_en,
  input  logic        i_byte_op,
  input  logic [31:0] i_alu_mem_addr,
  input  logic [31:0] i_mem_data_in,
  output logic [31:0] o_mem_data_out,
  output logic        o_mem_ready,
  output logic        o_mem_busy,
  output logic        o_mem_err
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_mem [MEM_WORDS];

  logic          w_byte_in;
  logic [AW-1:0] w_word_idx;
  logic [1:0]    w_lane;
  logic          w_out_of_range;
  logic          w_misaligned;
  logic          w_err;
  logic          w_last;
  logic          w_commit;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_load_val;

`ifdef MEM_BYTE_ACCESS_EN
  assign w_byte_in = i_byte_op;
`else
  // Byte accesses are compiled out; the input is kept on the port so the
  // interface is identical in both builds.
  logic w_unused_byte_op;
  assign w_unused_byte_op = i_byte_op;
  assign w_byte_in        = 1'b0;
`endif

  // All access decoding works from the latched request, so the address and
  // data inputs are free to change once the request has been accepted.
  assign w_word_idx     = r_addr[AW+1:2];
  assign w_lane         = r_addr[1:0];
  assign w_out_of_range = |r_addr[31:AW+2];
  assign w_misaligned   = !r_byte && (w_lane != 2'd0);
  assign w_err          = w_out_of_range || w_misaligned;

  // Final ACCESS cycle: the access happens on the edge that ends it.
  assign w_last   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  // A reset sampled on the commit edge aborts the store.
  assign w_commit = i_rst_n && w_last && r_wr && !w_err;

  assign w_rd_word = r_mem[w_word_idx];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_load_val = w_rd_word;
    if (r_byte) begin
      case (w_lane)
        2'd0:    w_load_val = {24'd0, w_rd_word[7:0]};
        2'd1:    w_load_val = {24'd0, w_rd_word[15:8]};
        2'd2:    w_load_val = {24'd0, w_rd_word[23:16]};
        default: w_load_val = {24'd0, w_rd_word[31:24]};
      endcase
    end
  end

  // NOTE: the memory array has no reset branch. Its contents survive reset,
  // and leaving it out lets the array map onto RAM instead of flops.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      if (r_byte) begin
        case (w_lane)
          2'd0:    r_mem[w_word_idx][7:0]   <= r_data[7:0];
          2'd1:    r_mem[w_word_idx][15:8]  <= r_data[7:0];
          2'd2:    r_mem[w_word_idx][23:16] <= r_data[7:0];
          default: r_mem[w_word_idx][31:24] <= r_data[7:0];
        endcase
      end else begin
        r_mem[w_word_idx] <= r_data;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_wr           <= 1'b0;
      r_byte         <= 1'b0;
      r_addr         <= 32'd0;
      r_data         <= 32'd0;
      o_mem_data_out <= 32'd0;
      o_mem_ready    <= 1'b0;
      o_mem_busy     <= 1'b0;
      o_mem_err      <= 1'b0;
    end else begin
      // Ready and err are pulses that are only high in DONE.
      o_mem_ready <= 1'b0;
      o_mem_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mem_start) begin
            r_wr       <= i_mem_wr_en;
            r_byte     <= w_byte_in;
            r_addr     <= i_alu_mem_addr;
            r_data     <= i_mem_data_in;
            r_cnt      <= 4'(WAIT_CYCLES);
            o_mem_busy <= 1'b1;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            o_mem_ready <= 1'b1;
            o_mem_err   <= w_err;
            if (!w_err && !r_wr) begin
              o_mem_data_out <= w_load_val;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_mem_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          o_mem_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
